// File: rtl/idc_pkg.sv
// Shared types and encodings for the decode-control queue: bundle layout,
// RV64IM opcode constants and the ALU operation codes used by ctrl/mctrl.
package idc_pkg;

  // Storage width of the pc/imm fields; narrower builds zero-extend into it.
  parameter int IDC_XLEN = 64;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_R32    = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd10;

  typedef struct packed {
    logic [IDC_XLEN-1:0] pc;
    logic [IDC_XLEN-1:0] imm;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                rf_wr_en;
    logic                do_jump;
    logic                is_branch;
    logic                is_debug;
    logic                alu_a_sel;
    logic                alu_b_sel;
    logic [3:0]          alu_ctrl;
    logic [2:0]          BrType;
    logic [1:0]          rf_wr_sel;
    logic                is_rs1_used;
    logic                is_rs2_used;
    logic                m_sel;
    logic [2:0]          dm_rd_ctrl;
    logic [2:0]          dm_wr_ctrl;
  } idc_bundle_t;

  typedef struct packed {
    logic       rf_wr_en;
    logic       do_jump;
    logic       is_branch;
    logic       is_debug;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [3:0] alu_ctrl;
    logic [2:0] BrType;
    logic [1:0] rf_wr_sel;
    logic       is_rs1_used;
    logic       is_rs2_used;
    logic [2:0] dm_rd_ctrl;
    logic [2:0] dm_wr_ctrl;
  } ctrl_sig_t;

  typedef struct packed {
    logic       m_sel;
    logic       rf_wr_en;
    logic [1:0] rf_wr_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [3:0] alu_ctrl;
  } mctrl_sig_t;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl.sv
// Base-ISA control decoder. rf_wr_sel: 0 alu, 1 memory, 2 pc+4.
module ctrl
  import idc_pkg::*;
(
  input  logic [31:0] inst,
  output ctrl_sig_t   out
);

  logic [2:0] f3;
  assign f3 = inst[14:12];

  always_comb begin
    out = '0;
    case (inst[6:0])
      OP_R, OP_R32: begin
        out.rf_wr_en    = 1'b1;
        out.alu_ctrl    = alu_op(f3, inst[30]);
        out.is_rs1_used = 1'b1;
        out.is_rs2_used = 1'b1;
      end
      OP_IMM, OP_IMM32: begin
        out.rf_wr_en    = 1'b1;
        out.alu_b_sel   = 1'b1;
        // Only shifts use bit 30 as an op modifier; addi has no subtract form.
        out.alu_ctrl    = alu_op(f3, (f3 == 3'd5) & inst[30]);
        out.is_rs1_used = 1'b1;
      end
      OP_LOAD: begin
        out.rf_wr_en    = 1'b1;
        out.alu_b_sel   = 1'b1;
        out.rf_wr_sel   = 2'd1;
        out.dm_rd_ctrl  = f3 + 3'd1;
        out.is_rs1_used = 1'b1;
      end
      OP_STORE: begin
        out.alu_b_sel   = 1'b1;
        out.dm_wr_ctrl  = f3 + 3'd1;
        out.is_rs1_used = 1'b1;
        out.is_rs2_used = 1'b1;
      end
      OP_BRANCH: begin
        out.is_branch   = 1'b1;
        out.BrType      = f3;
        out.alu_a_sel   = 1'b1;
        out.alu_b_sel   = 1'b1;
        out.is_rs1_used = 1'b1;
        out.is_rs2_used = 1'b1;
      end
      OP_JAL: begin
        out.rf_wr_en  = 1'b1;
        out.do_jump   = 1'b1;
        out.alu_a_sel = 1'b1;
        out.alu_b_sel = 1'b1;
        out.rf_wr_sel = 2'd2;
      end
      OP_JALR: begin
        out.rf_wr_en    = 1'b1;
        out.do_jump     = 1'b1;
        out.alu_b_sel   = 1'b1;
        out.rf_wr_sel   = 2'd2;
        out.is_rs1_used = 1'b1;
      end
      OP_LUI: begin
        out.rf_wr_en  = 1'b1;
        out.alu_b_sel = 1'b1;
        out.alu_ctrl  = ALU_COPY_B;
      end
      OP_AUIPC: begin
        out.rf_wr_en  = 1'b1;
        out.alu_a_sel = 1'b1;
        out.alu_b_sel = 1'b1;
      end
      OP_SYSTEM: begin
        out.is_debug = (inst == 32'h0010_0073);
      end
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/idc_decode.sv
// Combinational instruction decode into one queue bundle; M-extension
// control wins over base control for the fields both units drive.
module idc_decode
  import idc_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  output idc_bundle_t     bundle
);

  logic [XLEN-1:0] imm_val;
  ctrl_sig_t       c_sig;
  mctrl_sig_t      m_sig;

  imm #(.XLEN(XLEN)) u_imm (
    .inst (instruction),
    .out  (imm_val)
  );

  ctrl u_ctrl (
    .inst (instruction),
    .out  (c_sig)
  );

  mctrl u_mctrl (
    .opcode (instruction[6:0]),
    .funct3 (instruction[14:12]),
    .funct7 (instruction[31:25]),
    .out    (m_sig)
  );

  always_comb begin
    bundle             = '0;
    bundle.pc          = IDC_XLEN'(pc);
    bundle.imm         = IDC_XLEN'(imm_val);
    bundle.rd          = instruction[11:7];
    bundle.rs1         = instruction[19:15];
    bundle.rs2         = instruction[24:20];
    bundle.do_jump     = c_sig.do_jump;
    bundle.is_branch   = c_sig.is_branch;
    bundle.is_debug    = c_sig.is_debug;
    bundle.BrType      = c_sig.BrType;
    bundle.is_rs1_used = c_sig.is_rs1_used;
    bundle.is_rs2_used = c_sig.is_rs2_used;
    bundle.dm_rd_ctrl  = c_sig.dm_rd_ctrl;
    bundle.dm_wr_ctrl  = c_sig.dm_wr_ctrl;
    bundle.m_sel       = m_sig.m_sel;
    if (m_sig.m_sel) begin
      bundle.rf_wr_en  = m_sig.rf_wr_en;
      bundle.rf_wr_sel = m_sig.rf_wr_sel;
      bundle.alu_a_sel = m_sig.alu_a_sel;
      bundle.alu_b_sel = m_sig.alu_b_sel;
      bundle.alu_ctrl  = m_sig.alu_ctrl;
    end else begin
      bundle.rf_wr_en  = c_sig.rf_wr_en;
      bundle.rf_wr_sel = c_sig.rf_wr_sel;
      bundle.alu_a_sel = c_sig.alu_a_sel;
      bundle.alu_b_sel = c_sig.alu_b_sel;
      bundle.alu_ctrl  = c_sig.alu_ctrl;
    end
  end

endmodule

// File: rtl/imm.sv
// Immediate generator: sign-extended I/S/B/U/J immediate, XLEN bits wide.
module imm
  import idc_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] out
);

  always_comb begin
    out = '0;
    case (inst[6:0])
      OP_IMM, OP_IMM32, OP_LOAD, OP_JALR:
        out = XLEN'($signed(inst[31:20]));
      OP_STORE:
        out = XLEN'($signed({inst[31:25], inst[11:7]}));
      OP_BRANCH:
        out = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      OP_LUI, OP_AUIPC:
        out = XLEN'($signed({inst[31:12], 12'b0}));
      OP_JAL:
        out = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default:
        out = '0;
    endcase
  end

endmodule

// File: rtl/mctrl.sv
// M-extension control decoder; alu_ctrl carries {1, funct3} to select the mul/div op.
module mctrl
  import idc_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output mctrl_sig_t out
);

  always_comb begin
    out = '0;
    if ((opcode == OP_R || opcode == OP_R32) && funct7 == 7'b0000001) begin
      out.m_sel    = 1'b1;
      out.rf_wr_en = 1'b1;
      out.alu_ctrl = {1'b1, funct3};
    end
  end

endmodule

// File: rtl/pipeline_idc_queue.sv
// IF->ID decode-control queue: decoded bundles are buffered in a DEPTH-entry FIFO.
// Handshake: a beat transfers on a rising edge when valid & ready are both high and flush is low.
module pipeline_idc_queue
  import idc_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                instruction_IF,
  input  logic [XLEN-1:0]            pc_IFR,
  output logic                       out_valid,
  input  logic                       out_ready,
  output idc_bundle_t                out_bundle,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  idc_bundle_t   wr_bundle;
  idc_bundle_t   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  idc_decode #(.XLEN(XLEN)) u_decode (
    .instruction (instruction_IF),
    .pc          (pc_IFR),
    .bundle      (wr_bundle)
  );

  assign in_ready   = (count_q != CW'(DEPTH));
  assign out_valid  = (count_q != '0);
  assign push       = in_valid & in_ready & ~flush;
  assign pop        = out_valid & out_ready & ~flush;
  assign count      = count_q;
  // Empty queue presents a NOP bubble rather than stale storage.
  assign out_bundle = out_valid ? mem_q[rptr_q] : '0;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_bundle;
  end

endmodule

// File: doc/pipeline_idc_queue.md
# pipeline_idc_queue

Parametrised decode-control stage that replaces the single-register IF→ID control latch with a valid/ready-handshaked queue of decoded instruction bundles. Each accepted instruction is decoded combinationally by the existing `imm`, `ctrl` and `mctrl` units, merged with M-extension priority, and written into a DEPTH-entry FIFO. The EX-side consumer pops bundles independently, so a downstream stall no longer freezes fetch until the queue is full. The block sits between the IF register stage and the register-read/forwarding logic.

## Interface
Parameters:
- XLEN, 64: datapath width; 32 or 64. Applies to the PC and immediate fields.
- DEPTH, 4: number of queue entries; a power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all queued entries.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  queue can accept; equals !full.
- instruction_IF  in  32  raw instruction.
- pc_IFR  in  XLEN  PC of instruction_IF.
- out_valid  out  1  head entry is valid; equals !empty.
- out_ready  in  1  consumer accepts the head entry.
- out_bundle  out  idc_bundle_t  head entry, all-zero when empty (NOP bubble).
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Decode: imm = low XLEN bits of `imm.out`. When mctrl m_sel=1, rf_wr_en, rf_wr_sel, alu_a_sel, alu_b_sel and alu_ctrl are taken from mctrl; otherwise they come from ctrl. All other fields come from ctrl unchanged. rd = inst[11:7], rs1 = inst[19:15], rs2 = inst[24:20].
- push = in_valid & in_ready & !flush. pop = out_valid & out_ready & !flush.
- Write pointer, read pointer and count are each $clog2(DEPTH) / $clog2(DEPTH+1) bits wide. Pointers wrap modulo DEPTH through natural overflow.
- Push only: the entry is written at wptr, wptr increments and count increments.
- Pop only: rptr increments and count decrements.
- Push and pop in the same cycle: both pointers advance and count is unchanged. Push while full is impossible because in_ready=0. Pop while empty is impossible because out_valid=0.
- Flush: rptr=wptr=count=0 at the next edge. A same-cycle push and pop are both ignored. Stored data is not cleared; visibility is governed by count.
- Reset: the same as flush, applied asynchronously. The storage array is not reset.
- The queue has no bypass. in_ready does not depend combinationally on out_ready.

## Timing
- Latency is 1 cycle. An instruction accepted at edge N is presented on out_bundle with out_valid=1 after edge N, provided the queue was empty.
- Throughput is 1 bundle per cycle, sustained with in_valid=out_ready=1.
- Reset values: out_valid=0, in_ready=1, count=0, out_bundle=0.
- in_ready falls in the cycle after the push that makes count=DEPTH. It rises in the cycle after the first pop from full.
- out_bundle and out_valid are stable while out_valid=1 and out_ready=0.
- Entries are delivered strictly in FIFO order.

## Structure
- Package `idc_pkg` holds the packed struct `idc_bundle_t`, parametrised by XLEN through a package parameter. Its fields are pc, imm, rd, rs1, rs2, rf_wr_en, do_jump, is_branch, is_debug, alu_a_sel, alu_b_sel, alu_ctrl[3:0], BrType[2:0], rf_wr_sel[1:0], is_rs1_used, is_rs2_used, m_sel, dm_rd_ctrl[2:0] and dm_wr_ctrl[2:0].
- Sub-module `idc_decode` is purely combinational: instruction and pc in, idc_bundle_t out. It instantiates imm, ctrl and mctrl and applies the merge rule.
- The top level contains only the FIFO storage, pointers and handshake logic.

## Test plan
- After reset, push 0x00500093 (addi x1,x0,5) at pc 0x80000000 → next cycle out_valid=1, rd=1, rs1=0, imm=5, rf_wr_en=1, m_sel=0, pc=0x80000000, count=1.
- Push 0x022081B3 (mul x3,x1,x2) → m_sel=1, rd=3, rs1=1, rs2=2, and alu_ctrl equals mctrl's value rather than ctrl's.
- DEPTH=4, out_ready=0, in_valid held for 6 cycles with PCs 0,4,…,20 → exactly 4 accepted, in_ready=0 from cycle 5, count=4. Then out_ready=1 → PCs 0,4,8,12 pop in order, then out_valid=0.
- count=2, push and pop in the same cycle → count stays 2, and the head advances to the next PC.
- Full queue with in_valid=1, flush=1 for one cycle → next cycle count=0, out_valid=0, out_bundle=0, in_ready=1, and the flushed-cycle instruction is not enqueued.
- Assert reset asynchronously mid-burst, between clock edges → outputs immediately reach their reset values. After release, the first push is delivered correctly with count=1.
- XLEN=32 build: push lui 0xFFFFF0B7 → imm=0xFFFFF000 with 32-bit width.
